// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush-to-NOP and a
// saturating starvation counter. Define SKID_BUF_EN to add a skid entry that registers up_ready_o.
module pipe_stage_reg #(
  parameter int unsigned          PAYLOAD_W   = 64,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
  parameter int unsigned          CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 up_valid_i,
  output logic                 up_ready_o,
  input  logic [PAYLOAD_W-1:0] up_data_i,
  output logic                 dn_valid_o,
  input  logic                 dn_ready_i,
  output logic [PAYLOAD_W-1:0] dn_data_o,
  output logic [CNT_W-1:0]     starve_cnt_o
);

  logic                 main_valid_q, main_valid_d;
  logic [PAYLOAD_W-1:0] main_data_q,  main_data_d;
  logic [CNT_W-1:0]     cnt_q,        cnt_d;
  logic                 up_xfer, dn_xfer;

`ifdef SKID_BUF_EN
  logic                 skid_valid_q, skid_valid_d;
  logic [PAYLOAD_W-1:0] skid_data_q,  skid_data_d;
`endif

  assign dn_xfer = main_valid_q & dn_ready_i;
  assign up_xfer = up_valid_i & up_ready_o;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
`ifdef SKID_BUF_EN
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    up_ready_o   = ~skid_valid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      main_data_d  = NOP_PAYLOAD;
      skid_valid_d = 1'b0;
    end else if (dn_xfer) begin
      if (skid_valid_q) begin
        // Skid is older than anything arriving now; up_ready_o is low so nothing arrives.
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (up_xfer) begin
        main_data_d  = up_data_i;
      end else begin
        main_valid_d = 1'b0;
        main_data_d  = NOP_PAYLOAD;
      end
    end else if (up_xfer) begin
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_data_d  = up_data_i;
      end else begin
        main_valid_d = 1'b1;
        main_data_d  = up_data_i;
      end
    end
`else
    // Flush always drains the stage, so upstream may hand over (and lose) its payload.
    up_ready_o = flush_i | ~main_valid_q | dn_ready_i;
    if (flush_i) begin
      main_valid_d = 1'b0;
      main_data_d  = NOP_PAYLOAD;
    end else if (up_xfer) begin
      main_valid_d = 1'b1;
      main_data_d  = up_data_i;
    end else if (dn_xfer) begin
      main_valid_d = 1'b0;
      main_data_d  = NOP_PAYLOAD;
    end
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    if (dn_ready_i && !main_valid_q && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= NOP_PAYLOAD;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef SKID_BUF_EN
  // NOTE: skid data is qualified by skid_valid_q, so only the valid bit needs a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
    end
    skid_data_q <= skid_data_d;
  end
`endif

  assign dn_valid_o   = main_valid_q;
  assign dn_data_o    = main_data_q;
  assign starve_cnt_o = cnt_q;

endmodule
